// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one physical memory port.
// D-side is preferred; a starvation streak guarantees I-side progress.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic [15:0] i_rdata,
    output logic        i_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_addr,
    output logic [15:0] pmem_wdata,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY,
        DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [SW-1:0] r_streak;
    logic          r_pmem_read;
    logic          r_pmem_write;
    logic [15:0]   r_pmem_addr;
    logic [15:0]   r_pmem_wdata;
    logic          r_i_resp;
    logic          r_d_resp;
    logic [15:0]   r_i_rdata;
    logic [15:0]   r_d_rdata;

    logic w_d_req;
    logic w_grant_i;
    logic w_grant_d;

    assign w_d_req   = d_read | d_write;
    assign w_grant_i = i_req & (~w_d_req | (r_streak == LIM));
    assign w_grant_d = w_d_req & ~w_grant_i;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: arbitrate in IDLE, wait for memory in BUSY, one-cycle DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_i) begin
                    w_next = I_BUSY;
                end else if (w_grant_d) begin
                    w_next = D_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    w_next = DONE;
                end
            end
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Latch the granted request, drive the port, and capture read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_streak     <= '0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_pmem_addr  <= '0;
            r_pmem_wdata <= '0;
            r_i_resp     <= 1'b0;
            r_d_resp     <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_i_resp  <= 1'b0;
            r_d_resp  <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            case (r_state)
                IDLE: begin
                    if (w_grant_i) begin
                        r_pmem_read  <= 1'b1;
                        r_pmem_write <= 1'b0;
                        r_pmem_addr  <= i_addr;
                        r_pmem_wdata <= '0;
                        r_streak     <= '0;
                    end else if (w_grant_d) begin
                        r_pmem_read  <= ~d_write;
                        r_pmem_write <= d_write;
                        r_pmem_addr  <= d_addr;
                        r_pmem_wdata <= d_wdata;
                        if (i_req && (r_streak != LIM)) begin
                            r_streak <= r_streak + SW'(1);
                        end
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (pmem_resp) begin
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        if (r_state == I_BUSY) begin
                            r_i_resp  <= 1'b1;
                            r_i_rdata <= pmem_rdata;
                        end else begin
                            r_d_resp  <= 1'b1;
                            r_d_rdata <= pmem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign pmem_read  = r_pmem_read;
    assign pmem_write = r_pmem_write;
    assign pmem_addr  = r_pmem_addr;
    assign pmem_wdata = r_pmem_wdata;
    assign i_resp     = r_i_resp;
    assign d_resp     = r_d_resp;
    assign i_rdata    = r_i_rdata;
    assign d_rdata    = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level arbitration model.
module tb_mem_arbiter;

    localparam int LIM = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_addr;
    logic [15:0] pmem_wdata;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;

    int tests = 0;
    int fails = 0;
    int streak = 0;

    mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk),
        .rst(rst),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_rdata(i_rdata),
        .i_resp(i_resp),
        .d_read(d_read),
        .d_write(d_write),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_rdata(d_rdata),
        .d_resp(d_resp),
        .pmem_read(pmem_read),
        .pmem_write(pmem_write),
        .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rd"}, pmem_read, 0);
        chk({tag, "_wr"}, pmem_write, 0);
        chk({tag, "_iresp"}, i_resp, 0);
        chk({tag, "_dresp"}, d_resp, 0);
        chk({tag, "_irdata"}, i_rdata, 0);
        chk({tag, "_drdata"}, d_rdata, 0);
    endtask

    // Called at the negedge of the IDLE cycle in which requests are driven.
    // side: -1 = let the model decide, 0 = D expected, 1 = I expected.
    task automatic txn(input int k, input logic [15:0] rd,
                       input bit scramble, input int side);
        bit          gi;
        bit          dp;
        bit          wr;
        logic [15:0] ea;
        logic [15:0] ew;
        dp = d_read | d_write;
        if (side < 0) begin
            gi = i_req && (!dp || streak == LIM);
        end else begin
            gi = (side == 1);
        end
        if (gi) begin
            ea = i_addr;
            wr = 1'b0;
            ew = 16'h0;
            streak = 0;
        end else begin
            ea = d_addr;
            wr = d_write;
            ew = d_wdata;
            if (i_req && streak < LIM) streak++;
        end
        for (int c = 1; c <= k; c++) begin
            step();
            chk("busy_rd", pmem_read, !wr);
            chk("busy_wr", pmem_write, wr);
            chk("busy_addr", pmem_addr, ea);
            if (wr) chk("busy_wdata", pmem_wdata, ew);
            chk("busy_iresp", i_resp, 0);
            chk("busy_dresp", d_resp, 0);
            if (scramble) begin
                i_addr  = 16'($urandom);
                d_addr  = 16'($urandom);
                d_wdata = 16'($urandom);
                if ($urandom_range(0, 3) == 0) i_req = 1'b0;
                if ($urandom_range(0, 3) == 0) d_read = 1'b0;
                if ($urandom_range(0, 3) == 0) d_write = 1'b0;
            end
            pmem_resp  = (c == k);
            pmem_rdata = (c == k) ? rd : 16'($urandom);
        end
        step();
        chk("done_rd", pmem_read, 0);
        chk("done_wr", pmem_write, 0);
        chk("done_iresp", i_resp, gi);
        chk("done_dresp", d_resp, !gi);
        chk("done_irdata", i_rdata, gi ? rd : 16'h0);
        chk("done_drdata", d_rdata, gi ? 16'h0 : rd);
        pmem_resp  = 1'($urandom_range(0, 1));
        pmem_rdata = 16'($urandom);
        if (scramble) begin
            i_req  = 1'($urandom_range(0, 1));
            d_read = 1'($urandom_range(0, 1));
        end
        step();
        pmem_resp = 1'b0;
        chk_quiet("after");
    endtask

    initial begin
        rst        = 1'b1;
        i_req      = 1'b0;
        i_addr     = 16'h0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_addr     = 16'h0;
        d_wdata    = 16'h0;
        pmem_rdata = 16'h0;
        pmem_resp  = 1'b0;
        repeat (3) step();
        chk_quiet("reset");
        chk("reset_addr", pmem_addr, 0);
        chk("reset_wdata", pmem_wdata, 0);

        // Single fetch, requested while still in reset
        i_req  = 1'b1;
        i_addr = 16'h0010;
        rst    = 1'b0;
        txn(3, 16'h1234, 1'b0, 1);
        i_req = 1'b0;

        // Write whose data changes mid-transaction
        d_write = 1'b1;
        d_addr  = 16'h0200;
        d_wdata = 16'hBEEF;
        txn(4, 16'h5555, 1'b1, 0);
        d_write = 1'b0;
        d_read  = 1'b0;
        i_req   = 1'b0;

        // Read and write together act as a write
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 16'h0040;
        d_wdata = 16'hA5A5;
        txn(2, 16'h0001, 1'b0, 0);
        d_read  = 1'b0;
        d_write = 1'b0;

        // Sustained contention: D,D,D,I,D,D,D,I
        i_req  = 1'b1;
        i_addr = 16'h1111;
        d_read = 1'b1;
        d_addr = 16'h2222;
        for (int n = 0; n < 8; n++) begin
            txn(1 + (n % 3), 16'(16'h0100 + n), 1'b0, (n % 4 == 3) ? 1 : 0);
        end
        i_req  = 1'b0;
        d_read = 1'b0;

        // Fetch held through its response, then dropped
        i_req  = 1'b1;
        i_addr = 16'h0020;
        txn(2, 16'h7777, 1'b0, 1);
        i_req = 1'b0;
        step();
        chk_quiet("no_regrant");

        // Reset in the middle of a data read
        d_read = 1'b1;
        d_addr = 16'h0300;
        step();
        chk("pre_rst_rd", pmem_read, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_quiet("async_rst");
        d_read = 1'b0;
        streak = 0;
        step();
        step();
        rst = 1'b0;
        step();
        pmem_resp  = 1'b1;
        pmem_rdata = 16'hDEAD;
        step();
        pmem_resp = 1'b0;
        chk_quiet("stale_resp");
        step();
        chk_quiet("stale_resp2");
        d_read = 1'b1;
        d_addr = 16'h0301;
        txn(2, 16'h4242, 1'b0, 0);
        d_read = 1'b0;

        // Randomized traffic against the arbitration model
        for (int n = 0; n < 60; n++) begin
            i_req     = 1'($urandom_range(0, 1));
            d_read    = 1'($urandom_range(0, 1));
            d_write   = ($urandom_range(0, 2) == 0);
            i_addr    = 16'($urandom);
            d_addr    = 16'($urandom);
            d_wdata   = 16'($urandom);
            pmem_resp = 1'($urandom_range(0, 1));
            if (!i_req && !d_read && !d_write) begin
                step();
                pmem_resp = 1'b0;
                chk_quiet("rnd_idle");
            end else begin
                txn(int'($urandom_range(1, 4)), 16'($urandom),
                    1'($urandom_range(0, 1)), -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: consecutive contested D-side grants allowed before a pending I-side request SHALL win.
REQ-002 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 i_req  in  1  instruction-fetch read request, held until i_resp.
REQ-005 i_addr  in  16  fetch address (lc3b_word).
REQ-006 i_rdata  out  16  fetch read data, valid only while i_resp=1.
REQ-007 i_resp  out  1  one-cycle fetch completion pulse.
REQ-008 d_read  in  1  data-side read request, held until d_resp.
REQ-009 d_write  in  1  data-side write request, held until d_resp.
REQ-010 d_addr  in  16  data-side address.
REQ-011 d_wdata  in  16  data-side write data.
REQ-012 d_rdata  out  16  data-side read data, valid only while d_resp=1.
REQ-013 d_resp  out  1  one-cycle data-side completion pulse.
REQ-014 pmem_read  out  1  physical-port read strobe.
REQ-015 pmem_write  out  1  physical-port write strobe.
REQ-016 pmem_addr  out  16  physical-port address.
REQ-017 pmem_wdata  out  16  physical-port write data.
REQ-018 pmem_rdata  in  16  physical-port read data, valid with pmem_resp.
REQ-019 pmem_resp  in  1  physical-port completion, one or more cycles after the strobe.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, I_BUSY, D_BUSY and DONE.
REQ-021 IDLE arbitration: when only i_req is set, the FSM SHALL go to I_BUSY; when only d_read|d_write is set, it SHALL go to D_BUSY.
REQ-022 IDLE arbitration with both sides pending: D SHALL win unless streak==STARVE_LIMIT, in which case I SHALL win.
REQ-023 On entry to a BUSY state, the arbiter SHALL latch the granted side's address, write data and read/write type.
REQ-024 All pmem_* outputs SHALL be registered and driven from the latched values for the whole BUSY state; later changes on the requester inputs SHALL have no effect.
REQ-025 The first pmem strobe SHALL appear the cycle after the request is seen in IDLE.
REQ-026 When d_read and d_write are both set, the request SHALL be treated as a write.
REQ-027 A BUSY state SHALL hold until pmem_resp=1 is sampled; at that edge the FSM SHALL go to DONE and the pmem strobes SHALL drop.
REQ-028 In DONE, the arbiter SHALL assert i_resp or d_resp (granted side only) for exactly one cycle, with i_rdata/d_rdata holding pmem_rdata registered at the pmem_resp edge.
REQ-029 In DONE, all requests SHALL be ignored; DONE SHALL always return to IDLE.
REQ-030 Cycle timing: request at cycle 0, then strobe at cycles 1..k, pmem_resp at cycle k, resp at cycle k+1, and earliest new grant at cycle k+2.
REQ-031 i_rdata and d_rdata SHALL read 0 whenever their resp signal is 0.
REQ-032 i_resp and d_resp SHALL never be asserted in the same cycle.
REQ-033 pmem_resp SHALL be ignored in IDLE and DONE.
REQ-034 A request dropped during BUSY SHALL still complete, and its resp SHALL still pulse.
REQ-035 streak counter: 0..STARVE_LIMIT, saturating.
REQ-036 streak SHALL increment on a D grant made while i_req=1.
REQ-037 streak SHALL clear on any I grant.
REQ-038 streak SHALL be unchanged on an uncontested D grant.

Reset
REQ-039 While rst=1, regardless of clk: state=IDLE, streak=0, and every output (pmem_*, i_resp, d_resp, i_rdata, d_rdata) =0.
REQ-040 Reset mid-transaction SHALL abandon the transaction without producing a resp.
REQ-041 A stale pmem_resp arriving after reset SHALL be ignored.
REQ-042 The first arbitration SHALL occur on the first rising edge after rst falls.

Verification
REQ-043 Single fetch: i_req=1, i_addr=0x0010, pmem_resp on the 3rd strobe cycle with pmem_rdata=0x1234 -> pmem_read=1/pmem_addr=0x0010 for 3 cycles, then i_resp=1 and i_rdata=0x1234 for one cycle, d_resp=0 throughout.
REQ-044 Write: d_write=1, d_addr=0x0200, d_wdata=0xBEEF, then change d_wdata to 0 mid-BUSY -> pmem_write=1 with pmem_wdata=0xBEEF held until pmem_resp, then d_resp pulses once.
REQ-045 Contention with STARVE_LIMIT=3: i_req and d_read held continuously, each transaction re-requested after its resp -> grant order D,D,D,I,D,D,D,I; no two resps in one cycle.
REQ-046 Reset mid-operation: assert rst during D_BUSY, then pulse pmem_resp after rst falls -> all outputs 0 immediately, no d_resp, FSM IDLE, next d_read granted normally.
REQ-047 Back-to-back: requester keeps i_req=1 through i_resp, then deasserts -> exactly one transaction issued; DONE-cycle request not re-granted.
REQ-048 Simultaneous d_read=d_write=1, d_addr=0x0040 -> pmem_write=1, pmem_read=0.
